// File: rtl/prod_accumulator.sv
// Frame accumulator behind the 4x4 array multiplier: sums COUNT products and
// presents the registered frame sum. Optional `PROD_ACC_SAT_EN clamps on overflow.
module prod_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10,
  parameter int COUNT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(COUNT);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Hierarchically visible FSM state for checkers.
  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;

  logic             accept;
  logic             last_beat;
  logic [ACC_W:0]   sum_wide;
  logic             ovf_nxt;
  logic [ACC_W-1:0] acc_nxt;

  // Handshakes: a beat/result transfers on a rising clk edge where valid and
  // ready are both 1; valid never depends on ready, in_ready depends only on state.
  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt == CNT_W'(COUNT - 1));

  always_comb begin
    sum_wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    ovf_nxt  = ovf_sticky | sum_wide[ACC_W];
`ifdef PROD_ACC_SAT_EN
    acc_nxt  = ovf_nxt ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    acc_nxt  = sum_wide[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last_beat) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == ACCUM);
  end

  // clear outranks any same-cycle beat; out_sum/out_ovf keep their last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              out_sum    <= acc_nxt;
              out_ovf    <= ovf_nxt;
              out_valid  <= 1'b1;
              acc        <= '0;
              cnt        <= '0;
              ovf_sticky <= 1'b0;
            end else begin
              acc        <= acc_nxt;
              cnt        <= cnt + CNT_W'(1);
              ovf_sticky <= ovf_nxt;
            end
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: frame-level model checked every cycle plus
// hand-computed frame results in an expected queue.
module tb_prod_accumulator;

  localparam int PROD_W  = 8;
  localparam int ACC_W   = 10;
  localparam int COUNT   = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  int total = 0;
  int bad   = 0;

  // Hand-computed frame results, popped when out_valid rises.
  logic [ACC_W-1:0] exp_q[$];
  logic             exp_ovf_q[$];

  // Frame-level model: beats of the current frame and the presented result.
  int m_q[$];
  bit m_pending = 1'b0;
  int m_sum     = 0;
  bit m_ovf     = 1'b0;
  bit prev_valid = 1'b0;

  prod_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_close_frame();
    int t = 0;
    foreach (m_q[i]) t += m_q[i];
    m_ovf = (t > ACC_MAX);
`ifdef PROD_ACC_SAT_EN
    m_sum = m_ovf ? ACC_MAX : t;
`else
    m_sum = t % (ACC_MAX + 1);
`endif
    m_q.delete();
    m_pending = 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pending = 1'b0;
      m_sum     = 0;
      m_ovf     = 1'b0;
    end else if (clear) begin
      m_q.delete();
      m_pending = 1'b0;
    end else if (!m_pending) begin
      if (in_valid) begin
        m_q.push_back(int'(in_prod));
        if (m_q.size() == COUNT) model_close_frame();
      end
    end else if (out_ready) begin
      m_pending = 1'b0;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), int'(m_pending));
      chk("in_ready", int'(in_ready), int'(!m_pending));
      chk("out_sum", int'(out_sum), m_sum);
      chk("out_ovf", int'(out_ovf), int'(m_ovf));
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          chk("frame_sum", int'(out_sum), int'(exp_q.pop_front()));
          chk("frame_ovf", int'(out_ovf), int'(exp_ovf_q.pop_front()));
        end
      end
    end
    prev_valid = rst ? 1'b0 : out_valid;
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_beat(input logic [PROD_W-1:0] v);
    int budget = 50;
    in_valid = 1'b1;
    in_prod  = v;
    while (!in_ready && budget > 0) begin
      cycles(1);
      budget--;
    end
    chk("beat_wait", int'(in_ready), 1);
    cycles(1);
  endtask

  task automatic send_frame(input logic [PROD_W-1:0] v, input int gaps);
    for (int i = 0; i < COUNT; i++) begin
      send_beat(v);
      if (gaps != 0 && i != COUNT - 1) begin
        in_valid = 1'b0;
        cycles($urandom_range(0, 3));
      end
    end
  endtask

  task automatic expect_frame(input logic [ACC_W-1:0] s, input logic o);
    exp_q.push_back(s);
    exp_ovf_q.push_back(o);
  endtask

  initial begin
    logic [PROD_W-1:0] basic [COUNT];
    basic = '{8'd15, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90, 8'd105, 8'd120};

    #3;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_sum", int'(out_sum), 0);
    chk("reset_out_ovf", int'(out_ovf), 0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("reset_in_ready", int'(in_ready), 1);

    // Basic frame, back-to-back
    expect_frame(10'd540, 1'b0);
    for (int i = 0; i < COUNT; i++) send_beat(basic[i]);
    in_valid = 1'b0;
    chk("basic_valid_after_last", int'(out_valid), 1);
    chk("basic_busy", int'(in_ready), 0);
    cycles(1);
    chk("basic_ready_back", int'(in_ready), 1);
    chk("basic_valid_drop", int'(out_valid), 0);
    chk("basic_sum_kept", int'(out_sum), 540);
    cycles(2);

    // Overflow
`ifdef PROD_ACC_SAT_EN
    expect_frame(10'd1023, 1'b1);
`else
    expect_frame(10'd776, 1'b1);
`endif
    send_frame(8'd225, 0);
    in_valid = 1'b0;
    cycles(2);

    // Reset mid-frame after 3 beats of 0x10
    for (int i = 0; i < 3; i++) send_beat(8'h10);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_sum", int'(out_sum), 0);
    chk("midrst_out_ovf", int'(out_ovf), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    cycles(1);
    rst = 1'b0;
    cycles(1);
    expect_frame(10'd8, 1'b0);
    send_frame(8'h01, 0);
    in_valid = 1'b0;
    cycles(2);

    // Backpressure
    out_ready = 1'b0;
    expect_frame(10'd16, 1'b0);
    send_frame(8'h02, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_sum", int'(out_sum), 16);
      cycles(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(2);
    expect_frame(10'd32, 1'b0);
    send_frame(8'h04, 0);
    in_valid = 1'b0;
    cycles(2);

    // Bubbles
    expect_frame(10'd72, 1'b0);
    send_frame(8'd9, 1);
    in_valid = 1'b0;
    cycles(2);

    // Clear coincident with a beat
    for (int i = 0; i < 4; i++) send_beat(8'hFF);
    in_prod = 8'h01;
    clear   = 1'b1;
    cycles(1);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_no_valid", int'(out_valid), 0);
    cycles(2);
    expect_frame(10'd24, 1'b0);
    send_frame(8'h03, 0);
    in_valid = 1'b0;
    cycles(2);

    // Clear while a result is held
    out_ready = 1'b0;
    expect_frame(10'd8, 1'b0);
    send_frame(8'h01, 0);
    in_valid = 1'b0;
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    chk("clear_done_valid", int'(out_valid), 0);
    chk("clear_done_sum", int'(out_sum), 8);
    chk("clear_done_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    cycles(3);

    chk("frames_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit array multiplier; consumes its 8-bit product P.
- Sums a frame of COUNT products (dot-product / MAC building block) and presents the frame sum on a registered valid/ready output.
- Input side has a valid/ready handshake, so an upstream operand sequencer can drive A/B and qualify P with in_valid.

Parameters:
- PROD_W, 8, width of incoming product (multiplier P width).
- ACC_W, 10, accumulator and output sum width.
- COUNT, 8, products per frame; legal range 2..256; counter width is $clog2(COUNT).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous frame abort; highest priority after rst.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block accepts in_prod this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  out_sum/out_ovf hold a completed frame.
- out_ready  input  1  downstream accepts the frame result.
- out_sum  output  ACC_W  registered frame sum.
- out_ovf  output  1  frame sum exceeded 2^ACC_W-1.

Behaviour:
- Reset (async, rst=1): state=ACCUM, acc=0, cnt=0, ovf_sticky=0, out_valid=0, out_sum=0, out_ovf=0. in_ready=1 once rst deasserts.
- Accept condition: in_valid & in_ready, sampled on a rising clk edge. in_prod is zero-extended to ACC_W+1 bits before the add.
- State ACCUM:
  - in_ready=1.
  - On accept: acc <= acc + in_prod (mod 2^ACC_W); ovf_sticky |= carry out of bit ACC_W-1.
  - On accept with cnt != COUNT-1: cnt++.
  - On accept with cnt == COUNT-1: out_sum <= the new sum, out_valid <= 1, out_ovf <= updated ovf_sticky. acc, cnt and ovf_sticky go to 0. State goes to DONE.
  - No accept: registers hold.
- State DONE:
  - in_ready=0 (combinational from state); in_prod is ignored.
  - out_sum/out_ovf stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid <= 0, state goes to ACCUM. in_ready returns to 1 the following cycle.
  - out_sum and out_ovf keep the last value after out_valid drops.
- Latency: the last product is accepted on edge N; out_valid=1 after edge N. Minimum frame period is COUNT+1 cycles.
- out_ready while out_valid=0 has no effect.
- in_valid deasserted mid-frame: partial sum and count hold indefinitely (bubbles allowed).
- clear=1 (synchronous, any state):
  - acc=0, cnt=0, ovf_sticky=0, out_valid=0, state goes to ACCUM.
  - A same-cycle input beat is dropped: in_ready is 1 in ACCUM, but clear wins and the beat is not counted.
  - out_sum keeps its last value.
- rst asserted mid-frame or in DONE: immediate return to the reset values; a pending result is lost.
- All outputs are registered except in_ready.

Optional Feature:
- Macro: PROD_ACC_SAT_EN.
- Defined: a carry out of the accumulator clamps acc to 2^ACC_W-1. acc stays clamped for the rest of the frame, and out_sum reports the clamped value. out_ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W; out_ovf is the only overflow indication.

Test Plan:
- Reset: assert rst mid-frame after 3 beats of 0x10 -> all outputs 0 immediately; next frame of 8×0x01 gives out_sum=8, out_ovf=0.
- Basic frame: 8 back-to-back beats of 15,30,45,60,75,90,105,120 with out_ready=1 -> out_valid one cycle after the 8th beat; out_sum=540, out_ovf=0; in_ready=0 for exactly 1 cycle.
- Overflow: 8 beats of 225 (15×15) -> without macro out_sum=776, out_ovf=1; with PROD_ACC_SAT_EN out_sum=1023, out_ovf=1.
- Backpressure: complete a frame of 8×0x02, hold out_ready=0 for 5 cycles while in_valid=1 -> out_sum=16 stable, in_ready=0 throughout, no beats accepted. Release -> next frame starts from acc=0.
- Bubbles: 8 beats of 9 interleaved with random in_valid=0 gaps -> out_sum=72, exactly one out_valid pulse/hold per frame.
- Clear: 4 beats of 0xFF then clear=1 coincident with a 5th beat of 0x01 -> beat dropped, no out_valid. The following 8×0x03 frame gives out_sum=24, out_ovf=0.
